// File: rtl/amp_gain_loader.sv
// Purpose : debounces the board gain switches and shifts the mapped 8-bit gain word to the preamp over SPI.
// Latency : switch change accepted DEBOUNCE_CYCLES+2 (+/-1) cycles after settling; transfer holds amp_cs low 18*SPI_DIV cycles.
// Backpr. : none; changes seen during a transfer are held and compared again once the FSM returns to IDLE.
//
// Ports:
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   sw[3:0]           raw slide switches, asynchronous to clk
//   spi_sck           SPI clock, idles low
//   spi_mosi          SPI data, MSB first, changes only while spi_sck is low
//   amp_cs            preamplifier chip select, active low
//   busy              high while a transfer is in progress (low in the DONE cycle)
//   done              one-cycle pulse when a transfer completes
//   gain[7:0]         last word fully transferred to the amplifier
module amp_gain_loader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SPI_DIV         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       amp_cs,
    output logic       busy,
    output logic       done,
    output logic [7:0] gain
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DVW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(SPI_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [3:0]     sw_meta;
    logic [3:0]     sw_s;
    logic [3:0]     sw_prev;
    logic [DBW-1:0] db_cnt;
    logic [3:0]     sw_stable;
    logic           stable_vld;   // no switch value accepted yet after reset

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta    <= 4'h0;
            sw_s       <= 4'h0;
            sw_prev    <= 4'h0;
            db_cnt     <= '0;
            sw_stable  <= 4'h0;
            stable_vld <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
            sw_prev <= sw_s;

            if (sw_s != sw_prev) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end

            // sw_prev is the value the counter has been timing, even if
            // sw_s moves on this very cycle.
            if (db_cnt == DB_MAX) begin
                sw_stable  <= sw_prev;
                stable_vld <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Gain mapping: switch 3 mutes channel B
    // ------------------------------------------------------------------
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [7:0] word_map;

    assign nib_a    = {1'b0, sw_stable[2:0]};
    assign nib_b    = sw_stable[3] ? 4'h0 : nib_a;
    assign word_map = {nib_b, nib_a};

    // ------------------------------------------------------------------
    // Load request and SPI transfer FSM
    // ------------------------------------------------------------------
    state_t         state;
    logic [DVW-1:0] div_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic [7:0]     word_lat;
    logic [3:0]     pend_sw;
    logic [3:0]     loaded_sw;
    logic           never_loaded;
    logic           load_req;

    assign load_req = stable_vld && (never_loaded || (sw_stable != loaded_sw));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            word_lat     <= 8'h00;
            pend_sw      <= 4'h0;
            loaded_sw    <= 4'h0;
            never_loaded <= 1'b1;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
            amp_cs       <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            gain         <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state     <= ST_SETUP;
                        shift_reg <= word_map;
                        word_lat  <= word_map;
                        pend_sw   <= sw_stable;
                        amp_cs    <= 1'b0;
                        busy      <= 1'b1;
                        spi_mosi  <= word_map[7];
                        div_cnt   <= '0;
                    end
                end

                ST_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // Each bit: SPI_DIV cycles low, then SPI_DIV cycles high.
                // The next bit is driven on the same edge sck falls, so
                // mosi has a full low phase of setup before each rise.
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_HOLD;
                            end else begin
                                bit_cnt   <= bit_cnt + 3'd1;
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                spi_mosi  <= shift_reg[6];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt      <= '0;
                        state        <= ST_DONE;
                        amp_cs       <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        spi_mosi     <= 1'b0;
                        gain         <= word_lat;
                        loaded_sw    <= pend_sw;
                        never_loaded <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/amp_gain_loader.md
# amp_gain_loader

Loads the programmable preamplifier gain from the board slide switches. It takes the 4-bit switch vector, synchronises and debounces it, and maps it to an 8-bit gain word. On every settled change, and once after reset, it shifts that word to the preamplifier over SPI. It sits directly downstream of the switch source in the ADC project and upstream of the amplifier's SPI pins.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000 — consecutive clk cycles a synchronised switch value must hold before it is accepted (1 ms at 50 MHz).
- SPI_DIV, 4 — clk cycles per SCK half-period; must be ≥1 (4 gives 6.25 MHz at 50 MHz).

Ports:
- clk  in  1  system clock; every flop is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  4  raw slide switches, asynchronous to clk.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  SPI data, MSB first.
- amp_cs  out  1  preamplifier chip select, active low.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- gain  out  8  last word fully transferred to the amplifier.

## Operation
- **Input synchronisation:** sw passes through a 2-flop synchroniser to give sw_s.
- **Debounce:**
  - A counter resets to 0 whenever sw_s differs from its value on the previous cycle; otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES, sw_s becomes sw_stable.
- **Gain mapping:**
  - Channel A nibble = {1'b0, sw_stable[2:0]}.
  - Channel B nibble = sw_stable[3] ? 4'h0 : {1'b0, sw_stable[2:0]}.
  - word = {B, A}.
- **Load request:**
  - Raised when the FSM is in IDLE and either sw_stable has never been loaded since reset or sw_stable ≠ loaded_sw.
  - loaded_sw captures the switch value latched at the start of the transfer, once that transfer completes.
- **FSM states:**
  - IDLE → SETUP on a load request; word and switch value are latched into shift/pending registers.
  - SETUP: amp_cs low, first bit on spi_mosi, SPI_DIV cycles → SHIFT.
  - SHIFT: 8 bits, each SPI_DIV cycles with sck low, then SPI_DIV cycles with sck high. On each falling edge the next bit is driven. After the 8th bit's high phase, sck falls → HOLD.
  - HOLD: SPI_DIV cycles with sck low → DONE.
  - DONE: amp_cs high, done=1, gain ← latched word, loaded_sw ← pending value, 1 cycle → IDLE.
- **Switch change during a transfer:** ignored by the transfer in progress. Once back in IDLE, the new value is compared against loaded_sw and triggers a fresh transfer.
- **Reset values:**
  - spi_sck=0, spi_mosi=0, amp_cs=1, busy=0, done=0, gain=8'h00.
  - FSM=IDLE, debounce counter=0, "never loaded" flag set.

## Timing
- Synchroniser latency: 2 cycles. A sw change is accepted DEBOUNCE_CYCLES+2 cycles after it settles, ±1 cycle.
- amp_cs falls the cycle after a request is seen in IDLE.
- amp_cs stays low for exactly 18·SPI_DIV cycles: SETUP SPI_DIV + 16·SPI_DIV + HOLD SPI_DIV. It goes high on the same edge that done pulses.
- spi_mosi changes only while sck is low. The amplifier samples on the sck rising edge, so there are SPI_DIV cycles of setup and SPI_DIV cycles of hold.
- Exactly 8 sck rising edges per transfer.
- busy is high from the cycle amp_cs falls through the cycle before DONE; it is low in DONE.
- Minimum gap between transfers: 1 IDLE cycle (amp_cs high ≥2 cycles).
- rst_n low mid-transfer: outputs go to reset values immediately (asynchronously). After release, a fresh power-up load follows debounce.
- Simultaneous settle and DONE: the request is evaluated in IDLE only, one cycle later.

## Test plan
Bench settings: DEBOUNCE_CYCLES=8, SPI_DIV=2.
- **Power-up load:** sw=4'h3, release rst_n → one transfer with MOSI bits 8'h33, 8 sck rises, amp_cs low 36 cycles, done pulse, gain=8'h33.
- **Channel-B zero:** sw changes 4'h3→4'hB and holds → transfer 8'h03, gain=8'h03.
- **Bounce rejection:** sw toggles 4'h3↔4'h5 every 4 cycles for 40 cycles, then returns to 4'h3 → no transfer; amp_cs stays high.
- **Change during transfer:** sw 4'h3→4'h6 after power-up; midway through that transfer sw→4'h1 → first transfer completes with 8'h66, then a second transfer with 8'h11. done pulses twice, with amp_cs high ≥2 cycles between transfers.
- **Reset mid-transfer:** assert rst_n at bit 4 → amp_cs=1, sck=0, gain=8'h00 in the same cycle. After release, a full new transfer of the current switch word.
- **Timing check:** at every sck rising edge, mosi has been stable ≥2 cycles; sck=0 whenever amp_cs=1.
